// File: rtl/ahb3lite_sram_slave.sv
// AHB3-lite single-port SRAM slave with an address window, fixed wait states,
// byte/halfword/word lanes and a two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int          SIZE        = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          DEPTH = SIZE / 4;
  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, ADDR_BASE} + 33'(SIZE);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          write_reg, write_next;
  logic [3:0]    lane_reg, lane_next;

  logic [31:0] mem [0:DEPTH-1];

  logic        accept, legal, in_range, aligned, start;
  logic [31:0] offset, wmask;
  logic [3:0]  lane_dec;
  logic        phase_done, wr_en, rd_en;
  logic        unused_ok;

  assign accept = HSEL & HREADY & HTRANS[1];
  assign offset = HADDR - ADDR_BASE;

  // 33-bit compare so a window ending at 4 GiB cannot wrap back to zero.
  assign in_range = (HADDR >= ADDR_BASE) && ({1'b0, HADDR} < LIMIT);

  always_comb begin
    aligned  = 1'b0;
    lane_dec = 4'b0000;
    case (HSIZE)
      3'd0: begin aligned = 1'b1;                    lane_dec = 4'b0001 << HADDR[1:0]; end
      3'd1: begin aligned = ~HADDR[0];               lane_dec = HADDR[1] ? 4'b1100 : 4'b0011; end
      3'd2: begin aligned = (HADDR[1:0] == 2'b00);   lane_dec = 4'b1111; end
      default: begin aligned = 1'b0;                 lane_dec = 4'b0000; end
    endcase
  end

  assign legal = in_range & aligned;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      write_reg <= 1'b0;
      lane_reg  <= 4'b0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      write_reg <= write_next;
      lane_reg  <= lane_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    write_next = write_reg;
    lane_next  = lane_reg;
    start      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        start = accept;
        if (!accept) state_next = ST_IDLE;
      end
      ST_DATA: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          start = accept;
          if (!accept) state_next = ST_IDLE;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
    if (start) begin
      if (legal) begin
        state_next = ST_DATA;
        cnt_next   = WS;
        idx_next   = offset[IW+1:2];
        write_next = HWRITE;
        lane_next  = lane_dec;
      end else begin
        state_next = ST_ERR1;
        cnt_next   = 4'd0;
        write_next = 1'b0;
        lane_next  = 4'b0000;
      end
    end
  end

  assign phase_done = (state_reg == ST_DATA) && (cnt_reg == 4'd0);
  assign HREADYOUT  = (state_reg == ST_IDLE) || (state_reg == ST_ERR2) || phase_done;
  assign HRESP      = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

  // RESETn gates the commit so a reset on the final data cycle drops the write whole.
  assign wr_en = phase_done & write_reg & RESETn;
  assign rd_en = phase_done & ~write_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wmask[gi*8 +: 8] = {8{lane_reg[gi]}};
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[idx_reg] <= (mem[idx_reg] & ~wmask) | (HWDATA & wmask);
  end

  assign HRDATA = rd_en ? mem[idx_reg] : 32'h0;

  assign unused_ok = ^{HBURST, HPROT, offset[31:IW+2], offset[1:0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: a zero-wait slave and a two-wait-state slave share one bus.
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel0, sel2, block;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hreadyout0, hresp0, hreadyout2, hresp2;
  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hready2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign hready0 = hreadyout0 & ~block;
  assign hready2 = hreadyout2;

  ahb3lite_sram_slave #(.ADDR_BASE(32'h0), .SIZE(1024), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESETn(resetn), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HREADY(hready0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb3lite_sram_slave #(.ADDR_BASE(32'h0), .SIZE(1024), .WAIT_STATES(2)) dut2 (
    .CLK(clk), .RESETn(resetn), .HSEL(sel2), .HADDR(haddr), .HWDATA(hwdata),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
    .HREADY(hready2), .HREADYOUT(hreadyout2), .HRESP(hresp2), .HRDATA(hrdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] s);
    htrans = 2'd2;
    haddr  = a;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic idle_bus();
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; sel0 = 1'b0; sel2 = 1'b0; block = 1'b0;
    haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'd0; htrans = 2'd0;
    step(); step();
    resetn = 1'b1;
    chk("reset_hreadyout", {31'b0, hreadyout0}, 32'd1);
    chk("reset_hresp", {31'b0, hresp0}, 32'd0);
    chk("reset_hrdata", hrdata0, 32'h0);

    // word write then read, zero wait states
    sel0 = 1'b1;
    ap(32'h10, 1'b1, 3'd2);
    step();
    chk("wr_data_ready", {31'b0, hreadyout0}, 32'd1);
    hwdata = 32'hDEADBEEF;
    ap(32'h10, 1'b0, 3'd2);
    step();
    chk("rd_data_ready", {31'b0, hreadyout0}, 32'd1);
    chk("rd_word", hrdata0, 32'hDEADBEEF);
    idle_bus();
    step();
    chk("idle_hrdata_zero", hrdata0, 32'h0);

    // pipelined read-after-write to the same word
    ap(32'h8, 1'b1, 3'd2);
    step();
    hwdata = 32'h5A5A5A5A;
    ap(32'h8, 1'b0, 3'd2);
    step();
    chk("raw_read", hrdata0, 32'h5A5A5A5A);
    idle_bus();
    step();

    // byte and halfword lanes; unaddressed lanes carry junk that must not land
    ap(32'h0, 1'b1, 3'd2);
    step();
    hwdata = 32'h11223344;
    ap(32'h1, 1'b1, 3'd0);
    step();
    hwdata = 32'hEEEEAAEE;
    ap(32'h2, 1'b1, 3'd1);
    step();
    hwdata = 32'hBBCCEEEE;
    ap(32'h0, 1'b0, 3'd2);
    step();
    chk("lanes_read", hrdata0, 32'hBBCCAA44);
    idle_bus();
    step();

    // read one past the window
    ap(32'h400, 1'b0, 3'd2);
    step();
    idle_bus();
    chk("oob_err1_ready", {31'b0, hreadyout0}, 32'd0);
    chk("oob_err1_resp", {31'b0, hresp0}, 32'd1);
    step();
    chk("oob_err2_ready", {31'b0, hreadyout0}, 32'd1);
    chk("oob_err2_resp", {31'b0, hresp0}, 32'd1);
    step();
    chk("oob_after_resp", {31'b0, hresp0}, 32'd0);
    chk("oob_after_ready", {31'b0, hreadyout0}, 32'd1);

    // misaligned word write must error and leave memory untouched
    ap(32'h2, 1'b1, 3'd2);
    step();
    idle_bus();
    hwdata = 32'hFFFFFFFF;
    chk("misalign_resp", {31'b0, hresp0}, 32'd1);
    step();
    step();
    ap(32'h0, 1'b0, 3'd2);
    step();
    idle_bus();
    chk("misalign_mem_kept", hrdata0, 32'hBBCCAA44);
    step();

    // HSIZE=3 is illegal
    ap(32'h0, 1'b0, 3'd3);
    step();
    idle_bus();
    chk("hsize3_resp", {31'b0, hresp0}, 32'd1);
    step();
    step();

    // address below the base wraps to 0xFFFFFFFF and must error
    ap(32'hFFFFFFFF, 1'b0, 3'd0);
    step();
    idle_bus();
    chk("underflow_resp", {31'b0, hresp0}, 32'd1);
    step();
    step();

    // last word of the window is legal
    ap(32'h3FC, 1'b1, 3'd2);
    step();
    chk("last_word_resp", {31'b0, hresp0}, 32'd0);
    hwdata = 32'h0BADF00D;
    ap(32'h3FC, 1'b0, 3'd2);
    step();
    chk("last_word_read", hrdata0, 32'h0BADF00D);
    idle_bus();
    step();

    // another slave holds HREADY low: no accept, stay IDLE
    block = 1'b1;
    ap(32'h10, 1'b0, 3'd2);
    step();
    chk("blocked_ready", {31'b0, hreadyout0}, 32'd1);
    chk("blocked_no_read", hrdata0, 32'h0);
    idle_bus();
    block = 1'b0;
    step();
    sel0 = 1'b0;

    // two wait states: write then pipelined read
    sel2 = 1'b1;
    ap(32'h20, 1'b1, 3'd2);
    step();
    hwdata = 32'hCAFEF00D;
    ap(32'h20, 1'b0, 3'd2);
    chk("ws_wr_c0", {31'b0, hreadyout2}, 32'd0);
    step();
    chk("ws_wr_c1", {31'b0, hreadyout2}, 32'd0);
    step();
    chk("ws_wr_c2", {31'b0, hreadyout2}, 32'd1);
    step();
    chk("ws_rd_c0", {31'b0, hreadyout2}, 32'd0);
    chk("ws_rd_c0_data", hrdata2, 32'h0);
    step();
    chk("ws_rd_c1", {31'b0, hreadyout2}, 32'd0);
    step();
    chk("ws_rd_c2", {31'b0, hreadyout2}, 32'd1);
    chk("ws_rd_data", hrdata2, 32'hCAFEF00D);
    idle_bus();
    step();

    // reset on the final write data cycle drops the write
    ap(32'h20, 1'b1, 3'd2);
    step();
    idle_bus();
    hwdata = 32'h11111111;
    step();
    step();
    chk("rst_pre_ready", {31'b0, hreadyout2}, 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rst_ready", {31'b0, hreadyout2}, 32'd1);
    chk("rst_resp", {31'b0, hresp2}, 32'd0);
    ap(32'h20, 1'b0, 3'd2);
    step();
    idle_bus();
    step();
    step();
    chk("rst_write_dropped", hrdata2, 32'hCAFEF00D);
    step();
    sel2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
